// File: rtl/gci_std_display_pixel_buffer_pkg.sv
// Shared defaults and RGB565 helpers for the display pixel path.
//   DefDataWidth      : default pixel width (RGB565)
//   DefUnderflowColor : default pixel shown when the buffer runs dry
//   rgb565_r/g/b      : field extraction from a packed RGB565 pixel
//   rgb565_pack       : build a packed RGB565 pixel from its fields
package gci_std_display_pixel_buffer_pkg;

    localparam int unsigned DefDataWidth      = 16;
    localparam logic [15:0] DefUnderflowColor = 16'h0000;

    function automatic logic [4:0] rgb565_r(input logic [15:0] px);
        return px[15:11];
    endfunction

    function automatic logic [5:0] rgb565_g(input logic [15:0] px);
        return px[10:5];
    endfunction

    function automatic logic [4:0] rgb565_b(input logic [15:0] px);
        return px[4:0];
    endfunction

    function automatic logic [15:0] rgb565_pack(input logic [4:0] r, input logic [5:0] g,
                                                input logic [4:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/gci_std_display_sync_fifo.sv
// Single-clock FIFO: dual-port RAM, wrapping pointers, saturating-free level counter and a
// registered read port.
//   clk_i/rst_i   : clock, asynchronous active-high reset
//   clr_i         : synchronous clear of pointers and level
//   push_i        : write wr_data_i (caller guarantees not full)
//   pop_i         : read head into rd_data_o next cycle (caller guarantees not empty)
//   fill_i        : load FillValue into rd_data_o next cycle instead of a RAM read
//   rd_data_o     : registered read data, holds when neither pop_i nor fill_i
//   level_o       : current occupancy; level_next_o is the value after this edge
//   full_o/empty_o: decoded from the registered level
module gci_std_display_sync_fifo
    import gci_std_display_pixel_buffer_pkg::*;
#(
    parameter int unsigned          DataWidth = DefDataWidth,
    parameter int unsigned          DepthN    = 9,
    parameter logic [DataWidth-1:0] FillValue = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] wr_data_i,
    input  logic                 pop_i,
    input  logic                 fill_i,
    output logic [DataWidth-1:0] rd_data_o,
    output logic [DepthN:0]      level_o,
    output logic [DepthN:0]      level_next_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned Depth = 2 ** DepthN;

    logic [DataWidth-1:0] mem_q [Depth];

    logic [DepthN-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DepthN-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DepthN:0]      level_q, level_d;
    logic [DataWidth-1:0] rd_data_q, rd_data_d;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;

        if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q];
        end else if (fill_i) begin
            rd_data_d = FillValue;
        end

        if (push_i && !pop_i) begin
            level_d = level_q + 1'b1;
        end else if (pop_i && !push_i) begin
            level_d = level_q - 1'b1;
        end

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= FillValue;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    // RAM array has no reset so it can map onto block memory.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o    = rd_data_q;
    assign level_o      = level_q;
    assign level_next_o = level_d;
    assign full_o       = (level_q == (DepthN + 1)'(Depth));
    assign empty_o      = (level_q == '0);

endmodule

// File: rtl/gci_std_display_pixel_buffer.sv
// Pixel FIFO feeding the display timing generator.
//   iDISP_CLOCK / iRESET / iRESET_SYNC : clock, async reset, sync clear (same effect)
//   iWR_VALID / oWR_READY / iWR_DATA   : pixel input from the VRAM reader
//   iDATA_REQ / oDISP_DATA             : one pop per requesting cycle, data next cycle
//   iDATA_SYNC / oFRAME_START          : rising sync flushes; restart pulse the cycle after
//   oFETCH_REQ                         : refill request at or below the low watermark
//   oLEVEL                             : occupancy
//   oUNDERFLOW / iUNDERFLOW_CLR        : sticky empty-pop flag and its clear
module gci_std_display_pixel_buffer
    import gci_std_display_pixel_buffer_pkg::*;
#(
    parameter int unsigned             P_DATA_WIDTH      = DefDataWidth,
    parameter int unsigned             P_DEPTH_N         = 9,
    parameter int unsigned             P_LOW_WM          = 128,
    parameter logic [P_DATA_WIDTH-1:0] P_UNDERFLOW_COLOR = P_DATA_WIDTH'(DefUnderflowColor)
) (
    input  logic                    iDISP_CLOCK,
    input  logic                    iRESET,
    input  logic                    iRESET_SYNC,
    input  logic                    iWR_VALID,
    output logic                    oWR_READY,
    input  logic [P_DATA_WIDTH-1:0] iWR_DATA,
    input  logic                    iDATA_REQ,
    input  logic                    iDATA_SYNC,
    output logic [P_DATA_WIDTH-1:0] oDISP_DATA,
    output logic                    oFRAME_START,
    output logic                    oFETCH_REQ,
    output logic [P_DEPTH_N:0]      oLEVEL,
    output logic                    oUNDERFLOW,
    input  logic                    iUNDERFLOW_CLR
);

    localparam int unsigned LevelW = P_DEPTH_N + 1;

    logic              sync_prev_q, sync_prev_d;
    logic              active_q, active_d;
    logic              frame_start_q, frame_start_d;
    logic              fetch_q, fetch_d;
    logic              underflow_q, underflow_d;

    logic              flush;
    logic              wr_ready;
    logic              pop_req;
    logic              push;
    logic              pop;
    logic              underflow_hit;
    logic              fifo_full;
    logic              fifo_empty;
    logic [LevelW-1:0] fifo_level;
    logic [LevelW-1:0] fifo_level_next;

    always_comb begin
        flush         = iDATA_SYNC && !sync_prev_q && !iRESET_SYNC;
        // active_q keeps ready low for the first cycle out of reset.
        wr_ready      = active_q && !fifo_full && !flush && !iRESET_SYNC;
        pop_req       = iDATA_REQ && !flush && !iRESET_SYNC;
        push          = iWR_VALID && wr_ready;
        pop           = pop_req && !fifo_empty;
        // No bypass: an empty pop underflows even if a write lands this cycle.
        underflow_hit = pop_req && fifo_empty;

        sync_prev_d   = iRESET_SYNC ? 1'b0 : iDATA_SYNC;
        active_d      = !iRESET_SYNC;
        frame_start_d = flush;
        fetch_d       = !iRESET_SYNC && (fifo_level_next <= LevelW'(P_LOW_WM));

        // Set wins over clear.
        underflow_d = underflow_q;
        if (iUNDERFLOW_CLR) begin
            underflow_d = 1'b0;
        end
        if (underflow_hit) begin
            underflow_d = 1'b1;
        end
        if (iRESET_SYNC) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge iDISP_CLOCK or posedge iRESET) begin
        if (iRESET) begin
            sync_prev_q   <= 1'b0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            fetch_q       <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            sync_prev_q   <= sync_prev_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            fetch_q       <= fetch_d;
            underflow_q   <= underflow_d;
        end
    end

    // The FIFO read register doubles as the panel output register: it loads the head on a
    // pop, the underflow colour on an empty pop or sync clear, and holds otherwise.
    gci_std_display_sync_fifo #(
        .DataWidth (P_DATA_WIDTH),
        .DepthN    (P_DEPTH_N),
        .FillValue (P_UNDERFLOW_COLOR)
    ) u_fifo (
        .clk_i        (iDISP_CLOCK),
        .rst_i        (iRESET),
        .clr_i        (flush || iRESET_SYNC),
        .push_i       (push),
        .wr_data_i    (iWR_DATA),
        .pop_i        (pop),
        .fill_i       (underflow_hit || iRESET_SYNC),
        .rd_data_o    (oDISP_DATA),
        .level_o      (fifo_level),
        .level_next_o (fifo_level_next),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // During the flush cycle the buffer already presents as empty and not requesting.
    assign oWR_READY    = wr_ready;
    assign oLEVEL       = flush ? '0 : fifo_level;
    assign oFETCH_REQ   = fetch_q && !flush;
    assign oFRAME_START = frame_start_q;
    assign oUNDERFLOW   = underflow_q;

endmodule

// File: tb/tb_gci_std_display_pixel_buffer.sv
module tb_gci_std_display_pixel_buffer;

    logic        clk;
    logic        rst;
    logic        rst_sync;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        data_req;
    logic        data_sync;
    logic [15:0] disp_data;
    logic        frame_start;
    logic        fetch_req;
    logic [9:0]  level;
    logic        underflow;
    logic        underflow_clr;

    int checks = 0;
    int passes = 0;

    gci_std_display_pixel_buffer dut (
        .iDISP_CLOCK    (clk),
        .iRESET         (rst),
        .iRESET_SYNC    (rst_sync),
        .iWR_VALID      (wr_valid),
        .oWR_READY      (wr_ready),
        .iWR_DATA       (wr_data),
        .iDATA_REQ      (data_req),
        .iDATA_SYNC     (data_sync),
        .oDISP_DATA     (disp_data),
        .oFRAME_START   (frame_start),
        .oFETCH_REQ     (fetch_req),
        .oLEVEL         (level),
        .oUNDERFLOW     (underflow),
        .iUNDERFLOW_CLR (underflow_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_ready"}, wr_ready, 0);
        chk({tag, "_disp"}, disp_data, 16'h0000);
        chk({tag, "_fstart"}, frame_start, 0);
        chk({tag, "_fetch"}, fetch_req, 0);
        chk({tag, "_uflow"}, underflow, 0);
    endtask

    initial begin
        rst = 1'b0;
        rst_sync = 1'b0;
        wr_valid = 1'b0;
        wr_data = 16'h0;
        data_req = 1'b0;
        data_sync = 1'b0;
        underflow_clr = 1'b0;
        #1 rst = 1'b1;
        repeat (2) tick();
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();
        chk("post_reset_ready", wr_ready, 1);
        tick();
        chk("post_reset_fetch", fetch_req, 1);

        // Test 1: four pixels in, four out with one-cycle latency.
        for (int i = 1; i <= 4; i++) begin
            wr_valid = 1'b1;
            wr_data = 16'(i);
            tick();
        end
        wr_valid = 1'b0;
        #1;
        chk("t1_level4", level, 4);
        data_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("t1_disp%0d", i), disp_data, i);
            chk($sformatf("t1_level%0d", 4 - i), level, 4 - i);
        end
        data_req = 1'b0;
        tick();
        chk("t1_hold", disp_data, 16'h0004);

        // Test 3: empty pop with same-cycle write, no bypass.
        data_req = 1'b1;
        wr_valid = 1'b1;
        wr_data = 16'hABCD;
        #1;
        chk("t3_ready", wr_ready, 1);
        tick();
        data_req = 1'b0;
        wr_valid = 1'b0;
        #1;
        chk("t3_disp_uflow_color", disp_data, 16'h0000);
        chk("t3_uflow", underflow, 1);
        chk("t3_level", level, 1);
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        #1;
        chk("t3_disp_abcd", disp_data, 16'hABCD);
        chk("t3_level0", level, 0);

        // Test 6a: set beats clear.
        data_req = 1'b1;
        underflow_clr = 1'b1;
        tick();
        data_req = 1'b0;
        #1;
        chk("t6_set_over_clr", underflow, 1);
        tick();
        underflow_clr = 1'b0;
        #1;
        chk("t6_clr", underflow, 0);

        // Test 2: fill to 512; the 513th valid is refused.
        wr_valid = 1'b1;
        for (int i = 0; i < 512; i++) begin
            wr_data = 16'(i);
            tick();
        end
        wr_data = 16'h5555;
        #1;
        chk("t2_ready_full", wr_ready, 0);
        chk("t2_level_full", level, 512);
        chk("t2_fetch_full", fetch_req, 0);
        tick();
        wr_valid = 1'b0;
        #1;
        chk("t2_level_stays", level, 512);

        // Drain to 129; the first pixel out must be 0, not the refused 5555.
        data_req = 1'b1;
        tick();
        chk("t2_head_intact", disp_data, 16'h0000);
        repeat (382) tick();
        data_req = 1'b0;
        #1;
        chk("t5_level129", level, 129);
        chk("t5_disp382", disp_data, 16'h017E);
        chk("t5_fetch_low", fetch_req, 0);

        // Test 5: watermark crossing.
        data_req = 1'b1;
        tick();
        data_req = 1'b0;
        #1;
        chk("t5_level128", level, 128);
        chk("t5_fetch_rise", fetch_req, 1);
        chk("t5_disp383", disp_data, 16'h017F);
        wr_valid = 1'b1;
        wr_data = 16'h1111;
        tick();
        wr_valid = 1'b0;
        #1;
        chk("t5_level_back129", level, 129);
        chk("t5_fetch_fall", fetch_req, 0);

        // Test 4: frame flush from level 300.
        wr_valid = 1'b1;
        repeat (171) tick();
        wr_valid = 1'b0;
        #1;
        chk("t4_level300", level, 300);
        data_sync = 1'b1;
        wr_valid = 1'b1;
        data_req = 1'b1;
        #1;
        chk("t4_F_level", level, 0);
        chk("t4_F_ready", wr_ready, 0);
        chk("t4_F_fetch", fetch_req, 0);
        chk("t4_F_fstart", frame_start, 0);
        tick();
        wr_valid = 1'b0;
        data_req = 1'b0;
        #1;
        chk("t4_F1_fstart", frame_start, 1);
        chk("t4_F1_ready", wr_ready, 1);
        chk("t4_F1_level", level, 0);
        chk("t4_F1_fetch", fetch_req, 1);
        chk("t4_F1_no_uflow", underflow, 0);
        chk("t4_F1_disp_held", disp_data, 16'h017F);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t4_no_repulse%0d", i), frame_start, 0);
        end
        data_sync = 1'b0;
        tick();

        // Test 6b: async reset in the middle of a burst.
        wr_valid = 1'b1;
        wr_data = 16'h00A1;
        data_req = 1'b1;
        tick();
        wr_data = 16'h00A2;
        tick();
        data_req = 1'b0;
        wr_data = 16'h00A3;
        tick();
        chk("t6_burst_disp", disp_data, 16'h00A1);
        chk("t6_burst_level", level, 2);
        chk("t6_burst_uflow", underflow, 1);
        #1 rst = 1'b1;
        #1;
        chk_reset_outputs("t6_async");
        wr_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_ready_back", wr_ready, 1);
        chk("t6_no_fstart", frame_start, 0);

        // Synchronous clear behaves like reset.
        wr_valid = 1'b1;
        wr_data = 16'h0BEE;
        repeat (2) tick();
        rst_sync = 1'b1;
        #1;
        chk("sync_rst_ready", wr_ready, 0);
        tick();
        rst_sync = 1'b0;
        wr_valid = 1'b0;
        #1;
        chk("sync_rst_level", level, 0);
        chk("sync_rst_ready_low", wr_ready, 0);
        tick();
        chk("sync_rst_ready_back", wr_ready, 1);
        chk("sync_rst_fstart", frame_start, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
